// File: rtl/alu_scalar_arbiter.sv
// alu_scalar_arbiter: shares one external scalar ALU between NREQ requesters.
// Round-robin grant in IDLE, operands held in EXEC for ALU_LAT+1 cycles,
// result/flags returned to the granted requester in RESP.
// Optional per-requester accept counters: define ALU_ARB_STATS_EN.
//
//   state | meaning
//   IDLE  | waiting for any req_valid, grants combinationally
//   EXEC  | latched operands on alu_*, lat_cnt counting down to capture
//   RESP  | result held on resp_c/resp_nzvc until resp_ready of grantee
module alu_scalar_arbiter #(
  parameter int N       = 32,
  parameter int NREQ    = 4,
  parameter int ALU_LAT = 0
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [NREQ-1:0]     req_valid_i,
  output logic [NREQ-1:0]     req_ready_o,
  input  logic [NREQ*N-1:0]   req_a_i,
  input  logic [NREQ*N-1:0]   req_b_i,
  input  logic [NREQ*3-1:0]   req_sel_i,
  output logic [NREQ-1:0]     resp_valid_o,
  input  logic [NREQ-1:0]     resp_ready_i,
  output logic [N-1:0]        resp_c_o,
  output logic [3:0]          resp_nzvc_o,
  output logic [N-1:0]        alu_a_o,
  output logic [N-1:0]        alu_b_o,
  output logic [2:0]          alu_sel_o,
  input  logic [N-1:0]        alu_c_i,
  input  logic [3:0]          alu_nzvc_i,
  output logic                busy_o
`ifdef ALU_ARB_STATS_EN
  , output logic [NREQ*16-1:0] grant_cnt_o
`endif
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int LW = (ALU_LAT > 0) ? $clog2(ALU_LAT + 1) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]    state_q;
  logic [PW-1:0] rr_ptr_q;
  logic [PW-1:0] gid_q;
  logic [LW-1:0] lat_q;
  logic [N-1:0]  a_q, b_q, resp_c_q;
  logic [2:0]    sel_q;
  logic [3:0]    resp_nzvc_q;

  logic          gnt_found;
  logic [PW-1:0] gnt_idx;
  logic [PW-1:0] gnt_next;
  logic          accept;

  // Round-robin search starting at rr_ptr; wrap is explicit so NREQ need not be a power of two
  always_comb begin
    logic [PW:0]   sum;
    logic [PW-1:0] cand;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    sum       = '0;
    cand      = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum = {1'b0, rr_ptr_q} + (PW+1)'(k);
      if (sum >= (PW+1)'(NREQ)) sum = sum - (PW+1)'(NREQ);
      cand = sum[PW-1:0];
      if (!gnt_found && req_valid_i[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  assign accept   = (state_q == S_IDLE) && gnt_found;
  assign gnt_next = (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;

  assign req_ready_o  = accept ? (NREQ'(1) << gnt_idx) : '0;
  assign resp_valid_o = (state_q == S_RESP) ? (NREQ'(1) << gid_q) : '0;
  assign resp_c_o     = resp_c_q;
  assign resp_nzvc_o  = resp_nzvc_q;
  assign alu_a_o      = (state_q == S_EXEC) ? a_q : '0;
  assign alu_b_o      = (state_q == S_EXEC) ? b_q : '0;
  assign alu_sel_o    = (state_q == S_EXEC) ? sel_q : 3'b000;
  assign busy_o       = (state_q == S_EXEC) || (state_q == S_RESP);

  // Control FSM with operand latch, latency countdown and result capture
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= '0;
      gid_q       <= '0;
      lat_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      sel_q       <= 3'b000;
      resp_c_q    <= '0;
      resp_nzvc_q <= 4'b0000;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (gnt_found) begin
            a_q      <= req_a_i[int'(gnt_idx)*N +: N];
            b_q      <= req_b_i[int'(gnt_idx)*N +: N];
            sel_q    <= req_sel_i[int'(gnt_idx)*3 +: 3];
            gid_q    <= gnt_idx;
            rr_ptr_q <= gnt_next;
            lat_q    <= LW'(ALU_LAT);
            state_q  <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (lat_q == '0) begin
            resp_c_q    <= alu_c_i;
            resp_nzvc_q <= alu_nzvc_i;
            state_q     <= S_RESP;
          end else begin
            lat_q <= lat_q - 1'b1;
          end
        end
        S_RESP: begin
          if (resp_ready_i[gid_q]) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef ALU_ARB_STATS_EN
  logic [15:0] gcnt_q [NREQ];

  // Per-requester accept counters, wrap naturally at 16 bits
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NREQ; i++) gcnt_q[i] <= 16'h0000;
    end else if (accept) begin
      gcnt_q[gnt_idx] <= gcnt_q[gnt_idx] + 16'h0001;
    end
  end

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_cnt_out
    assign grant_cnt_o[gi*16 +: 16] = gcnt_q[gi];
  end
`endif

endmodule

// File: tb/tb_alu_scalar_arbiter.sv
// Directed bench for alu_scalar_arbiter: one instance with ALU_LAT=0 and one
// with ALU_LAT=3, each driven by a small behavioural ALU in the bench.
module tb_alu_scalar_arbiter;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [3:0]   req_valid = '0, req_valid3 = '0;
  logic [3:0]   resp_ready = '0, resp_ready3 = '0;
  logic [127:0] req_a = '0, req_b = '0;
  logic [11:0]  req_sel = '0;

  logic [3:0]  req_ready, resp_valid, resp_nzvc, alu_nzvc;
  logic [31:0] resp_c, alu_a, alu_b, alu_c;
  logic [2:0]  alu_sel;
  logic        busy;
  logic [3:0]  req_ready3, resp_valid3, resp_nzvc3, alu_nzvc3;
  logic [31:0] resp_c3, alu_a3, alu_b3, alu_c3;
  logic [2:0]  alu_sel3;
  logic        busy3;
`ifdef ALU_ARB_STATS_EN
  logic [63:0] gcnt, gcnt3;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  alu_scalar_arbiter #(.N(32), .NREQ(4), .ALU_LAT(0)) u0 (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_a_i(req_a), .req_b_i(req_b), .req_sel_i(req_sel),
    .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
    .resp_c_o(resp_c), .resp_nzvc_o(resp_nzvc),
    .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_sel_o(alu_sel),
    .alu_c_i(alu_c), .alu_nzvc_i(alu_nzvc), .busy_o(busy)
`ifdef ALU_ARB_STATS_EN
    , .grant_cnt_o(gcnt)
`endif
  );

  alu_scalar_arbiter #(.N(32), .NREQ(4), .ALU_LAT(3)) u3 (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid3), .req_ready_o(req_ready3),
    .req_a_i(req_a), .req_b_i(req_b), .req_sel_i(req_sel),
    .resp_valid_o(resp_valid3), .resp_ready_i(resp_ready3),
    .resp_c_o(resp_c3), .resp_nzvc_o(resp_nzvc3),
    .alu_a_o(alu_a3), .alu_b_o(alu_b3), .alu_sel_o(alu_sel3),
    .alu_c_i(alu_c3), .alu_nzvc_i(alu_nzvc3), .busy_o(busy3)
`ifdef ALU_ARB_STATS_EN
    , .grant_cnt_o(gcnt3)
`endif
  );

  // Behavioural ALU: returns {N,Z,V,C,result}; sub sets C on borrow
  function automatic logic [35:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic [2:0] s);
    logic [32:0] w;
    logic [63:0] p;
    logic [31:0] c;
    logic        v, cy;
    w = '0; p = '0; c = '0; v = 1'b0; cy = 1'b0;
    case (s)
      3'b001: c = a;
      3'b010: begin
        w  = {1'b0, a} + {1'b0, b};
        c  = w[31:0];
        cy = w[32];
        v  = (a[31] == b[31]) && (c[31] != a[31]);
      end
      3'b011: begin
        c  = a - b;
        cy = (a < b);
        v  = (a[31] != b[31]) && (c[31] != a[31]);
      end
      3'b100: begin
        p  = {32'b0, a} * {32'b0, b};
        c  = p[31:0];
        v  = |p[63:32];
        cy = v;
      end
      3'b101: c = (b == 32'd0) ? 32'd0 : a / b;
      default: c = 32'd0;
    endcase
    return {c[31], (c == 32'd0), v, cy, c};
  endfunction

  assign {alu_nzvc, alu_c}   = alu_model(alu_a, alu_b, alu_sel);
  assign {alu_nzvc3, alu_c3} = alu_model(alu_a3, alu_b3, alu_sel3);

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] s);
    req_a[i*32 +: 32] = a;
    req_b[i*32 +: 32] = b;
    req_sel[i*3 +: 3] = s;
  endtask

  // One full transaction on the ALU_LAT=0 instance from a single requester
  task automatic do_op(input string tag, input int i, input logic [31:0] a,
                       input logic [31:0] b, input logic [2:0] s,
                       input logic [31:0] ec, input logic [3:0] ef);
    logic [3:0] oh;
    oh = 4'b0001 << i;
    set_req(i, a, b, s);
    req_valid = oh;
    #1;
    chk({tag, "_ready"}, req_ready, oh);
    tick();
    req_valid = '0;
    chk({tag, "_alu"}, {busy, alu_sel, alu_a, alu_b, resp_valid}, {1'b1, s, a, b, 4'b0000});
    tick();
    chk({tag, "_rvalid"}, resp_valid, oh);
    chk({tag, "_c"}, resp_c, ec);
    chk({tag, "_nzvc"}, resp_nzvc, ef);
    resp_ready = oh;
    tick();
    resp_ready = '0;
    chk({tag, "_idle"}, {busy, resp_valid}, 5'b0);
  endtask

  int exp_g[5] = '{0, 1, 2, 3, 0};

  initial begin
    #1;
    chk("rst_u0", {req_ready, resp_valid, resp_c, resp_nzvc, alu_a, alu_b, alu_sel, busy}, '0);
    chk("rst_u3", {req_ready3, resp_valid3, resp_c3, alu_a3, alu_sel3, busy3}, '0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    do_op("add",    0, 32'd5,        32'd7, 3'b010, 32'd12,       4'b0000);
    do_op("subneg", 1, 32'd3,        32'd5, 3'b011, 32'hFFFFFFFE, 4'b1001);
    do_op("subz",   1, 32'd9,        32'd9, 3'b011, 32'd0,        4'b0100);
    do_op("carry",  1, 32'hFFFFFFFF, 32'd1, 3'b010, 32'd0,        4'b0101);
    do_op("illeg",  3, 32'd55,       32'd3, 3'b110, 32'd0,        4'b0100);
    do_op("ovf",    2, 32'h7FFFFFFF, 32'd1, 3'b010, 32'h80000000, 4'b1010);
    do_op("pass",   0, 32'h80000000, 32'd4, 3'b001, 32'h80000000, 4'b1000);
    do_op("div",    3, 32'd100,      32'd7, 3'b101, 32'd14,       4'b0000);

    // All four requesters valid: rotation 0,1,2,3,0 with each own result
    for (int i = 0; i < 4; i++) set_req(i, 32'(10 * (i + 1)), 32'(i + 1), 3'b010);
    req_valid  = 4'b1111;
    resp_ready = 4'b1111;
    #1;
    for (int k = 0; k < 5; k++) begin
      chk("rr_ready", req_ready, 4'b0001 << exp_g[k]);
      tick();
      tick();
      chk("rr_rvalid", resp_valid, 4'b0001 << exp_g[k]);
      chk("rr_c", resp_c, 32'(11 * (exp_g[k] + 1)));
      tick();
    end
    req_valid  = '0;
    resp_ready = '0;

    // Back-pressure on requester 2; other resp_ready bits must be ignored
    set_req(2, 32'd100, 32'd23, 3'b011);
    req_valid = 4'b0100;
    #1;
    chk("bp_ready", req_ready, 4'b0100);
    tick();
    req_valid = '0;
    tick();
    req_valid  = 4'b1111;
    resp_ready = 4'b1011;
    for (int k = 0; k < 10; k++) begin
      #1;
      chk("bp_hold", {resp_valid, resp_c, resp_nzvc, req_ready, busy},
          {4'b0100, 32'd77, 4'b0000, 4'b0000, 1'b1});
      tick();
    end
    resp_ready = 4'b0100;
    tick();
    resp_ready = '0;
    chk("bp_release", {busy, resp_valid}, 5'b0);
    chk("bp_nextptr", req_ready, 4'b1000);
    req_valid = '0;
    #1;

    // Multi-cycle ALU: operands stable for 4 cycles, result at T+5
    set_req(1, 32'd6, 32'd7, 3'b100);
    req_valid3 = 4'b0010;
    #1;
    chk("lat_ready", req_ready3, 4'b0010);
    tick();
    req_valid3 = '0;
    for (int k = 0; k < 4; k++) begin
      chk("lat_alu", {alu_sel3, alu_a3, alu_b3, resp_valid3, busy3},
          {3'b100, 32'd6, 32'd7, 4'b0000, 1'b1});
      tick();
    end
    chk("lat_rvalid", resp_valid3, 4'b0010);
    chk("lat_c", {resp_c3, resp_nzvc3}, {32'd42, 4'b0000});
    chk("lat_alu_off", {alu_sel3, alu_a3}, 35'd0);
    resp_ready3 = 4'b0010;
    tick();
    resp_ready3 = '0;
    chk("lat_idle", {busy3, resp_valid3}, 5'b0);

    // Asynchronous reset while EXEC
    set_req(0, 32'd1, 32'd1, 3'b010);
    req_valid = 4'b0001;
    tick();
    req_valid = '0;
    chk("mid_exec", busy, 1'b1);
    rst = 1'b1;
    #1;
    chk("mid_rst", {req_ready, resp_valid, resp_c, resp_nzvc, alu_a, alu_b, alu_sel, busy}, '0);
`ifdef ALU_ARB_STATS_EN
    chk("stats_rst", gcnt, 64'd0);
`endif
    tick();
    rst = 1'b0;
    req_valid = 4'b1111;
    #1;
    chk("rst_ptr", req_ready, 4'b0001);
    req_valid = '0;
    #1;
    do_op("post_rst", 2, 32'd1, 32'd2, 3'b010, 32'd3, 4'b0000);
`ifdef ALU_ARB_STATS_EN
    chk("stats_inc", gcnt, 64'h0000_0001_0000_0000);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
